// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract engine: one 4-bit adder is stepped over the
// operands LSB nibble first, with the inter-nibble carry held in a register.

module fulladder4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);

  logic [4:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
  assign o_s    = w_sum[3:0];
  assign o_cout = w_sum[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_cout;
  logic             r_ovf;

  logic [IDX_W+1:0] w_bit_base;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s;
  logic             w_cout4;

  assign w_bit_base = {r_idx, 2'b00};
  assign w_a_nib    = r_a[w_bit_base +: 4];
  assign w_b_nib    = r_b[w_bit_base +: 4];

  fulladder4 u_fa (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout4)
  );

  // Control FSM and datapath; subtract is folded into ~B with carry-in of 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_sub ? ~in_b : in_b;
            r_carry    <= in_sub;
            r_idx      <= {IDX_W{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_sum[w_bit_base +: 4] <= w_s;
          r_carry                <= w_cout4;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_cout4;
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
            r_idx       <= {IDX_W{1'b0}};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases plus
// randomized operations compared against an arithmetic reference model.

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sub);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
    if (sub) begin
      res  = a - b;
      cout = (a >= b);
      ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      res  = full[WIDTH-1:0];
      cout = full[WIDTH];
      ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    end
    return {ovf, cout, res};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sub, input int bp, input logic tog);
    logic [WIDTH+1:0] e;
    e = ref_op(a, b, sub);
    wait_ready();
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("acc_rdy", 32'(in_ready), 32'd0);
    for (int c = 1; c <= NIB; c++) begin
      if (tog) begin
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_sub   = 1'($urandom);
        in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      if (c == NIB) chk("lat_valid", 32'(out_valid), 32'd1);
      else          chk("run_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("sum",      32'(out_sum),  32'(e[WIDTH-1:0]));
    chk("cout",     32'(out_cout), 32'(e[WIDTH]));
    chk("ovf",      32'(out_ovf),  32'(e[WIDTH+1]));
    chk("done_rdy", 32'(in_ready), 32'd0);
    if (bp > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        in_valid = 1'b1;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        @(posedge clk); #1;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_rdy",   32'(in_ready),  32'd0);
        chk("bp_sum",   32'(out_sum),   32'(e[WIDTH-1:0]));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("hs_valid", 32'(out_valid), 32'd0);
    chk("hs_rdy",   32'(in_ready),  32'd1);
    chk("hold_sum", 32'(out_sum),   32'(e[WIDTH-1:0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",   32'(in_ready),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",   32'(out_sum),   32'd0);
    chk("rst_cout",  32'(out_cout),  32'd0);
    chk("rst_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    do_op(16'hA5A5, 16'h1111, 1'b0, 10, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);
    do_op(16'h9ABC, 16'h1357, 1'b1, 0, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);

    // Abort an operation two cycles into RUN.
    wait_ready();
    in_a = 16'h1234; in_b = 16'h4321; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_rdy",   32'(in_ready),  32'd0);
    chk("abort_sum",   32'(out_sum),   32'd0);
    chk("abort_cout",  32'(out_cout),  32'd0);
    chk("abort_ovf",   32'(out_ovf),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rdy1", 32'(in_ready), 32'd1);
    do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int               rbp;
      ra  = WIDTH'($urandom);
      rb  = (k % 7 == 0) ? ra : WIDTH'($urandom);
      rbp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_op(ra, rb, 1'($urandom_range(0, 1)), rbp, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
